muldiv_sequencer: RTL and testbench

- Iterative signed multiply/divide engine and sequencer that owns the HI/LO register pair.
- Control pulses a start and then waits for done or div0. The HI/LO outputs feed the MFHI/MFLO paths.
- The block shares one shift/add-subtract datapath between MULT and DIV. Requests arriving while it is busy are never accepted.

---
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide sequencer that owns the HI/LO register pair.
// MULT and DIV share one shift/add-subtract datapath; latency is WIDTH+2 edges.
// Optional MULDIV_MTHILO_EN adds direct HI/LO writes (mthi_i/mtlo_i/wr_data_i) in IDLE.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mult_start_i,
    input  logic             div_start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef MULDIV_MTHILO_EN
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wr_data_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e             state_q;
    logic               busy_q, done_q, div0_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               op_div_q;
    logic               neg_res_q, neg_rem_q;
    logic [CntW-1:0]    cnt_q;
    // upper_q: product high half (MULT) or remainder (DIV)
    // lower_q: multiplier being shifted out (MULT) or quotient being shifted in (DIV)
    logic [WIDTH-1:0]   upper_q, lower_q, opnd_q;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH+1:0]   alu_a, alu_b, alu_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Magnitudes, shared adder/subtractor and final sign correction.
    always_comb begin
        abs_a    = a_q[WIDTH-1] ? ('0 - a_q) : a_q;
        abs_b    = b_q[WIDTH-1] ? ('0 - b_q) : b_q;
        // DIV trial-subtracts the divisor from the WIDTH+1-bit shifted partial remainder;
        // MULT conditionally adds the multiplicand to the high half.
        alu_a    = op_div_q ? {1'b0, upper_q, lower_q[WIDTH-1]} : {2'b00, upper_q};
        alu_b    = (op_div_q || lower_q[0]) ? {2'b00, opnd_q} : '0;
        alu_res  = op_div_q ? (alu_a - alu_b) : (alu_a + alu_b);
        prod     = {upper_q, lower_q};
        prod_fix = neg_res_q ? ('0 - prod) : prod;
        quot_fix = neg_res_q ? ('0 - lower_q) : lower_q;
        rem_fix  = neg_rem_q ? ('0 - upper_q) : upper_q;
    end

    // Sequencer FSM with registered status outputs and HI/LO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            opnd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                StIdle: begin
`ifdef MULDIV_MTHILO_EN
                    if (mthi_i) hi_q <= wr_data_i;
                    if (mtlo_i) lo_q <= wr_data_i;
`endif
                    if (mult_start_i || div_start_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        op_div_q <= !mult_start_i;  // mult wins a tie
                        busy_q   <= 1'b1;
                        state_q  <= StPrep;
                    end
                end
                StPrep: begin
                    if (op_div_q && (b_q == '0)) begin
                        div0_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        upper_q   <= '0;
                        lower_q   <= op_div_q ? abs_a : abs_b;
                        opnd_q    <= op_div_q ? abs_b : abs_a;
                        neg_res_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        neg_rem_q <= a_q[WIDTH-1];
                        cnt_q     <= '0;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (op_div_q) begin
                        // Restoring step: keep the difference only if it did not go negative.
                        if (!alu_res[WIDTH+1]) begin
                            upper_q <= alu_res[WIDTH-1:0];
                        end else begin
                            upper_q <= {upper_q[WIDTH-2:0], lower_q[WIDTH-1]};
                        end
                        lower_q <= {lower_q[WIDTH-2:0], !alu_res[WIDTH+1]};
                    end else begin
                        upper_q <= alu_res[WIDTH:1];
                        lower_q <= {alu_res[0], lower_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (op_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results computed
// with plain signed arithmetic; a negedge monitor pops and compares on done/div0.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    typedef struct {
        bit          is_div0;
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge_no;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mult_start_i(mult_start),
        .div_start_i (div_start),
        .a_i         (a),
        .b_i         (b),
        .busy_o      (busy),
        .done_o      (done),
        .div0_o      (div0),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: signed product, or truncating quotient with remainder signed like a.
    function automatic void model(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                                  output bit z, output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sbv, p, q, r;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        z   = 1'b0;
        rh  = '0;
        rl  = '0;
        if (is_div) begin
            if (bv == 0) begin
                z = 1'b1;
            end else begin
                q  = sa / sbv;
                r  = sa % sbv;
                rl = q[31:0];
                rh = r[31:0];
            end
        end else begin
            p  = sa * sbv;
            rh = p[63:32];
            rl = p[31:0];
        end
    endfunction

    // Call at a negedge: drives a start for one edge and optionally queues its expectation.
    task automatic issue(input bit m, input bit d, input logic [31:0] av, input logic [31:0] bv,
                         input string name, input bit push);
        exp_t e;
        bit   z;
        logic [31:0] rh, rl;
        model(!m, av, bv, z, rh, rl);
        e.is_div0 = z;
        e.hi      = rh;
        e.lo      = rl;
        e.edge_no = cyc + 1 + (z ? 1 : LAT);
        e.name    = name;
        if (push) sb.push_back(e);
        mult_start = m;
        div_start  = d;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Counts busy cycles until idle; returns at the negedge where busy is low.
    task automatic wait_idle(input string name, input int exp_len);
        int n = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) check({name, "_idle_timeout"}, 64'd1, 64'd0);
        else if (exp_len >= 0) check({name, "_busy_len"}, 64'(n), 64'(exp_len));
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: on each done/div0 pop the oldest expectation; otherwise HI/LO must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_hi <= '0;
            model_lo <= '0;
        end else if (done || div0) begin
            if (sb.size() == 0) begin
                check("spurious_event", {62'd0, done, div0}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_kind"}, {62'd0, done, div0}, e.is_div0 ? 64'd1 : 64'd2);
                check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
                if (e.is_div0) begin
                    check({e.name, "_hi"}, 64'(hi), 64'(model_hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(model_lo));
                end else begin
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    model_hi <= e.hi;
                    model_lo <= e.lo;
                end
            end
        end else begin
            check("hilo_hold", {hi, lo}, {model_hi, model_lo});
        end
    end

    initial begin
        int n_done;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done_div0", {62'd0, done, div0}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 0, 32'd7, 32'hFFFF_FFFD, "mult_7_m3", 1);
        wait_idle("mult_7_m3", LAT);
        issue(0, 1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1);
        wait_idle("div_m7_2", LAT);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 1);
        wait_idle("div_min_m1", LAT);
        issue(1, 0, 32'd3, 32'd5, "mult_3_5", 1);
        wait_idle("mult_3_5", LAT);
        issue(0, 1, 32'd9, 32'd0, "div_by0", 1);
        wait_idle("div_by0", 1);
        issue(1, 1, 32'd6, 32'd4, "both_start", 1);
        wait_idle("both_start", LAT);

        // A second start while busy must be dropped.
        issue(1, 0, 32'd1234, 32'hFFFF_FFB3, "busy_ignore", 1);
        repeat (9) @(negedge clk);
        mult_start = 1'b1;
        div_start  = 1'b1;
        a = 32'd5;
        b = 32'd5;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        wait_idle("busy_ignore", -1);

        // Randomized back-to-back and gapped operations.
        for (int i = 0; i < 60; i++) begin
            bit is_mult;
            logic [31:0] av, bv;
            is_mult = $urandom_range(0, 1) == 1;
            av = rnd_opnd();
            bv = rnd_opnd();
            issue(is_mult, !is_mult, av, bv, is_mult ? "rnd_mult" : "rnd_div", 1);
            wait_idle("rnd", (!is_mult && bv == 0) ? 1 : LAT);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Make HI/LO nonzero, then reset mid-RUN: everything clears, no done follows.
        issue(1, 0, 32'h0001_2345, 32'h0000_6789, "pre_reset", 1);
        wait_idle("pre_reset", LAT);
        issue(1, 0, 32'd11, 32'd13, "aborted", 0);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || div0) n_done++;
        end
        check("no_done_after_reset", 64'(n_done), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);

        issue(0, 1, 32'd100, 32'hFFFF_FFF9, "post_reset_div", 1);
        wait_idle("post_reset_div", LAT);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
